duv_ser_tx: RTL and testbench

Two-lane parallel-to-serial transmitter that generates the serial `in_a`/`in_b` bit streams consumed by the DUV shift-register front end. It accepts one word pair per valid/ready handshake and shifts both words out MSB-first, one bit per clock. During each word it asserts a frame strobe, then holds a configurable idle gap. It sits between the bench/stimulus sequencer and the DUV serial inputs.

---
 rtl/duv_ser_tx.sv | 203 ++++++++++++++++++++
 tb/tb_duv_ser_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/duv_ser_tx.sv
// duv_ser_tx
// Two-lane parallel-to-serial transmitter feeding the DUV shift-register
// front end (ser_a -> in_a, ser_b -> in_b). One word pair is captured per
// valid/ready handshake and shifted out MSB first on both lanes in lockstep,
// with ser_frame high for the frame bits. A programmable idle gap follows
// each frame before the next accept.
//
// Optional feature macro: DUV_SER_TX_PARITY_EN
//   defined   : each lane appends one even-parity bit after bit 0 (NBITS = WIDTH+1)
//   undefined : data bits only (NBITS = WIDTH), no parity logic
//
// Parameters
//   WIDTH       data bits per lane per frame (2..32)
//   GAP_CYCLES  idle cycles after each frame (0..255)
//
// Ports
//   clk        in   rising-edge clock
//   arst_n     in   asynchronous active-low reset
//   s_valid    in   word pair offered
//   s_ready    out  transmitter can accept (registered)
//   s_data_a   in   lane A word
//   s_data_b   in   lane B word
//   ser_a      out  lane A serial bit
//   ser_b      out  lane B serial bit
//   ser_frame  out  high while ser_a/ser_b carry frame bits
//   busy       out  high in SHIFT or GAP
//   frame_cnt  out  completed-frame count, wraps at 256
//
// FSM states
//   state    | meaning
//   ST_IDLE  | waiting for a handshake, s_ready high (from the first edge after reset)
//   ST_SHIFT | frame bits on ser_a/ser_b, bit_cnt = index of bit on the lines
//   ST_GAP   | idle spacing, gap_tmr counts down to zero

module duv_ser_tx #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data_a,
    input  logic [WIDTH-1:0] s_data_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_frame,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

`ifdef DUV_SER_TX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam int            CW       = 6;
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
    // Timer counts GAP_CYCLES-1 down to 0, so the GAP state lasts GAP_CYCLES edges.
    localparam logic [7:0]    GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

`ifdef DUV_SER_TX_PARITY_EN
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, sh_a_nxt, sh_b_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]       gap_tmr, gap_tmr_nxt;
    logic [7:0]       frame_cnt_nxt;
    logic             ser_a_nxt, ser_b_nxt, frame_nxt;
    logic             ready_nxt, busy_nxt;
    logic             accept;

`ifdef DUV_SER_TX_PARITY_EN
    logic par_a, par_b, par_a_nxt, par_b_nxt;
`endif

    // s_ready is only ever high in IDLE, so this also implies state == ST_IDLE.
    assign accept = s_valid & s_ready;

    always_comb begin
        state_nxt     = state;
        sh_a_nxt      = sh_a;
        sh_b_nxt      = sh_b;
        bit_cnt_nxt   = bit_cnt;
        gap_tmr_nxt   = gap_tmr;
        frame_cnt_nxt = frame_cnt;
        ser_a_nxt     = 1'b0;
        ser_b_nxt     = 1'b0;
        frame_nxt     = 1'b0;
`ifdef DUV_SER_TX_PARITY_EN
        par_a_nxt     = par_a;
        par_b_nxt     = par_b;
`endif

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt   = ST_SHIFT;
                    // MSB goes straight to the output register; the shift
                    // register keeps the remaining bits left-aligned.
                    ser_a_nxt   = s_data_a[WIDTH-1];
                    ser_b_nxt   = s_data_b[WIDTH-1];
                    sh_a_nxt    = {s_data_a[WIDTH-2:0], 1'b0};
                    sh_b_nxt    = {s_data_b[WIDTH-2:0], 1'b0};
                    frame_nxt   = 1'b1;
                    bit_cnt_nxt = '0;
`ifdef DUV_SER_TX_PARITY_EN
                    par_a_nxt   = ^s_data_a;
                    par_b_nxt   = ^s_data_b;
`endif
                end
            end

            ST_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    frame_cnt_nxt = frame_cnt + 8'd1;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_GAP;
                        gap_tmr_nxt = GAP_LOAD;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CW'(1);
                    frame_nxt   = 1'b1;
`ifdef DUV_SER_TX_PARITY_EN
                    if (bit_cnt == DATA_LAST) begin
                        ser_a_nxt = par_a;
                        ser_b_nxt = par_b;
                    end else
`endif
                    begin
                        ser_a_nxt = sh_a[WIDTH-1];
                        ser_b_nxt = sh_b[WIDTH-1];
                        sh_a_nxt  = {sh_a[WIDTH-2:0], 1'b0};
                        sh_b_nxt  = {sh_b[WIDTH-2:0], 1'b0};
                    end
                end
            end

            ST_GAP: begin
                if (gap_tmr == 8'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_tmr_nxt = gap_tmr - 8'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt  = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ST_IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            bit_cnt   <= '0;
            gap_tmr   <= '0;
            frame_cnt <= '0;
            ser_a     <= 1'b0;
            ser_b     <= 1'b0;
            ser_frame <= 1'b0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
`ifdef DUV_SER_TX_PARITY_EN
            par_a     <= 1'b0;
            par_b     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sh_a      <= sh_a_nxt;
            sh_b      <= sh_b_nxt;
            bit_cnt   <= bit_cnt_nxt;
            gap_tmr   <= gap_tmr_nxt;
            frame_cnt <= frame_cnt_nxt;
            ser_a     <= ser_a_nxt;
            ser_b     <= ser_b_nxt;
            ser_frame <= frame_nxt;
            s_ready   <= ready_nxt;
            busy      <= busy_nxt;
`ifdef DUV_SER_TX_PARITY_EN
            par_a     <= par_a_nxt;
            par_b     <= par_b_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_duv_ser_tx.sv
// Testbench for duv_ser_tx. Two instances share the stimulus: index 0 uses
// GAP_CYCLES=1, index 1 uses GAP_CYCLES=0. Both are checked every cycle
// against a timeline model (outputs derived from the cycle offset since the
// last accept), plus table vectors and hand-written corner sequences.

module tb_duv_ser_tx;

    localparam int W = 8;
`ifdef DUV_SER_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic       clk = 1'b0;
    logic       arst_n;
    logic       s_valid;
    logic [7:0] s_data_a, s_data_b;

    logic       rdy0, sa0, sb0, fr0, busy0;
    logic       rdy1, sa1, sb1, fr1, busy1;
    logic [7:0] fc0, fc1;

    always #5 clk = ~clk;

    duv_ser_tx #(.WIDTH(W), .GAP_CYCLES(1)) u_gap1 (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(rdy0),
        .s_data_a(s_data_a), .s_data_b(s_data_b),
        .ser_a(sa0), .ser_b(sb0), .ser_frame(fr0), .busy(busy0), .frame_cnt(fc0)
    );

    duv_ser_tx #(.WIDTH(W), .GAP_CYCLES(0)) u_gap0 (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(rdy1),
        .s_data_a(s_data_a), .s_data_b(s_data_b),
        .ser_a(sa1), .ser_b(sb1), .ser_frame(fr1), .busy(busy1), .frame_cnt(fc1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int         gapc [2] = '{1, 0};
    int         t = 0;
    int         acc_t [2];
    logic [7:0] wa [2], wb [2];
    int         fcnt [2];
    logic       m_rdy [2], m_busy [2], m_fr [2], m_sa [2], m_sb [2];

    function automatic logic lane_bit(input logic [7:0] w, input int d);
        if (d < W) return w[W-1-d];
        return ^w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            acc_t[i] = -100000;
            fcnt[i]  = 0;
            m_rdy[i] = 1'b0; m_busy[i] = 1'b0; m_fr[i] = 1'b0;
            m_sa[i]  = 1'b0; m_sb[i]   = 1'b0;
        end
    endtask

    // Called right after a rising edge with the inputs that edge sampled.
    task automatic model_edge();
        int d;
        if (!arst_n) return;
        t++;
        for (int i = 0; i < 2; i++) begin
            if (s_valid && m_rdy[i]) begin
                acc_t[i] = t;
                wa[i] = s_data_a;
                wb[i] = s_data_b;
            end
            d = t - acc_t[i];
            if (d == NB) fcnt[i] = (fcnt[i] + 1) % 256;
            m_fr[i]   = (d >= 0) && (d < NB);
            m_sa[i]   = m_fr[i] ? lane_bit(wa[i], d) : 1'b0;
            m_sb[i]   = m_fr[i] ? lane_bit(wb[i], d) : 1'b0;
            m_busy[i] = (d >= 0) && (d < NB + gapc[i]);
            m_rdy[i]  = !m_busy[i];
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("s_ready",   0, 32'(rdy0),  32'(m_rdy[0]));
        chk("ser_a",     0, 32'(sa0),   32'(m_sa[0]));
        chk("ser_b",     0, 32'(sb0),   32'(m_sb[0]));
        chk("ser_frame", 0, 32'(fr0),   32'(m_fr[0]));
        chk("busy",      0, 32'(busy0), 32'(m_busy[0]));
        chk("frame_cnt", 0, 32'(fc0),   32'(fcnt[0]));
        chk("s_ready",   1, 32'(rdy1),  32'(m_rdy[1]));
        chk("ser_a",     1, 32'(sa1),   32'(m_sa[1]));
        chk("ser_b",     1, 32'(sb1),   32'(m_sb[1]));
        chk("ser_frame", 1, 32'(fr1),   32'(m_fr[1]));
        chk("busy",      1, 32'(busy1), 32'(m_busy[1]));
        chk("frame_cnt", 1, 32'(fc1),   32'(fcnt[1]));
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
        s_valid  = v;
        s_data_a = a;
        s_data_b = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        arst_n = 1'b0;
        model_reset();
        repeat (cycles) step(1'b0, 8'h00, 8'h00);
        arst_n = 1'b1;
    endtask

    // Sends one word pair through instance 0 and reassembles the serial stream.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] ea, input logic [7:0] eb,
                              input logic pa, input logic pb);
        int guard = 0;
        int cycles = 0;
        int fr_len = 0;
        logic [NB-1:0] ca = '0, cb = '0;
        while (!(m_rdy[0] && m_rdy[1]) && guard < 50) begin
            step(1'b0, 8'($urandom), 8'($urandom));
            guard++;
        end
        chk("ready_wait", 0, 32'(guard < 50), 32'd1);
        step(1'b1, a, b);
        ca = {ca[NB-2:0], sa0}; cb = {cb[NB-2:0], sb0}; fr_len += int'(fr0);
        for (int k = 1; k < NB; k++) begin
            // Data and valid wiggle during SHIFT; only the captured word may appear.
            step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            cycles++;
            ca = {ca[NB-2:0], sa0}; cb = {cb[NB-2:0], sb0}; fr_len += int'(fr0);
        end
        step(1'b0, 8'($urandom), 8'($urandom));
        cycles++;
        fr_len += int'(fr0);
        while (!rdy0 && cycles < 50) begin
            step(1'b0, 8'($urandom), 8'($urandom));
            cycles++;
        end
        chk("lane_a_word", 0, 32'(ca[NB-1 -: W]), 32'(ea));
        chk("lane_b_word", 0, 32'(cb[NB-1 -: W]), 32'(eb));
`ifdef DUV_SER_TX_PARITY_EN
        chk("lane_a_parity", 0, 32'(ca[0]), 32'(pa));
        chk("lane_b_parity", 0, 32'(cb[0]), 32'(pb));
`else
        if (pa !== pb) begin end
`endif
        chk("frame_len", 0, 32'(fr_len), 32'(NB));
        chk("ready_latency", 0, 32'(cycles), 32'(NB + 1));
    endtask

    typedef struct {
        logic [7:0] a, b, ea, eb;
        logic       pa, pb;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, cyc, n_int, g;
        logic prev;

        vecs[0] = '{a: 8'hA5, b: 8'h3C, ea: 8'hA5, eb: 8'h3C, pa: 1'b0, pb: 1'b0};
        vecs[1] = '{a: 8'h07, b: 8'h00, ea: 8'h07, eb: 8'h00, pa: 1'b1, pb: 1'b0};
        vecs[2] = '{a: 8'hFF, b: 8'h01, ea: 8'hFF, eb: 8'h01, pa: 1'b0, pb: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h7F, ea: 8'h80, eb: 8'h7F, pa: 1'b1, pb: 1'b1};
        vecs[4] = '{a: 8'h00, b: 8'hC3, ea: 8'h00, eb: 8'hC3, pa: 1'b0, pb: 1'b0};

        arst_n = 1'b0; s_valid = 1'b0; s_data_a = '0; s_data_b = '0;
        model_reset();

        // Reset held for 3 cycles, then the table vectors.
        do_reset(3);
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb, vecs[i].pa, vecs[i].pb);
            if (i == 0) chk("frame_cnt_first", 0, 32'(fc0), 32'd1);
        end

        // Back-to-back on the GAP_CYCLES=0 instance: s_ready rises every NB+1 edges.
        prev = rdy1; last = -1; cyc = 0; n_int = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b1, 8'($urandom), 8'($urandom));
            cyc++;
            if (rdy1 && !prev) begin
                if (last >= 0) begin
                    chk("b2b_spacing", 1, 32'(cyc - last), 32'(NB + 1));
                    n_int++;
                end
                last = cyc;
            end
            prev = rdy1;
        end
        chk("b2b_intervals_seen", 1, 32'(n_int >= 3), 32'd1);

        // Mid-frame reset after the 4th bit.
        do_reset(2);
        g = 0;
        while (!(m_rdy[0] && m_rdy[1]) && g < 20) begin
            step(1'b0, 8'h00, 8'h00);
            g++;
        end
        step(1'b1, 8'h5A, 8'hC3);
        repeat (3) step(1'b0, 8'h00, 8'h00);
        #2;
        arst_n = 1'b0;
        #1;
        chk("rst_s_ready", 0, 32'(rdy0), 0);  chk("rst_s_ready", 1, 32'(rdy1), 0);
        chk("rst_ser_a", 0, 32'(sa0), 0);     chk("rst_ser_a", 1, 32'(sa1), 0);
        chk("rst_ser_b", 0, 32'(sb0), 0);     chk("rst_ser_b", 1, 32'(sb1), 0);
        chk("rst_frame", 0, 32'(fr0), 0);     chk("rst_frame", 1, 32'(fr1), 0);
        chk("rst_busy", 0, 32'(busy0), 0);    chk("rst_busy", 1, 32'(busy1), 0);
        chk("rst_frame_cnt", 0, 32'(fc0), 0); chk("rst_frame_cnt", 1, 32'(fc1), 0);
        model_reset();
        repeat (2) step(1'b1, 8'hFF, 8'hFF);
        arst_n = 1'b1;
        send_frame(8'h96, 8'h69, 8'h96, 8'h69, 1'b0, 1'b0);
        chk("post_rst_frame_cnt", 0, 32'(fc0), 32'd1);
        chk("post_rst_frame_cnt", 1, 32'(fc1), 32'd1);

        // frame_cnt wrap on instance 0.
        do_reset(2);
        g = 0;
        while (fc0 != 8'd255 && g < 4000) begin
            step(1'b1, 8'($urandom), 8'($urandom));
            g++;
        end
        chk("wrap_reach_255", 0, 32'(fc0), 32'd255);
        g = 0;
        while (fc0 == 8'd255 && g < 30) begin
            step(1'b1, 8'($urandom), 8'($urandom));
            g++;
        end
        chk("wrap_to_0", 0, 32'(fc0), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
